// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for the 3-stage core
// (fetch -> decode_execute -> memory_writeback).
// Owns the per-stage valid bits and stage-advance enables; resolves
// load-use stalls, branch/jump redirects, memory-busy freezes and
// flash (fence.i/ecall) drains. No datapath passes through here.
//
// Handshake note: there is no valid/ready pair in this block. Stage
// advance is a plain enable: a stage register loads when its enable is
// high in a cycle, and the matching *_valid bit describes what it holds.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_valid,
    input  logic [4:0]       de_rs1_num,
    input  logic [4:0]       de_rs2_num,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             flash,
    input  logic             mw_busy,
    input  logic             mw_is_load,
    input  logic             mw_wb_reg,
    input  logic [4:0]       mw_rd_num,
    output logic             fetch_en,
    output logic             pc_load,
    output logic             de_valid,
    output logic             mw_en,
    output logic             mw_valid,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic             de_valid_q, de_valid_d;
    logic             mw_valid_q, mw_valid_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic fetch_en_c, pc_load_c, mw_en_c;
    logic redir_hz, lu_hz, flash_hz;

    // Hazard terms only matter when decode_execute holds a live instruction.
    assign redir_hz = de_valid_q & (br_taken | jump);
    assign flash_hz = de_valid_q & flash;
    assign lu_hz    = de_valid_q & mw_valid_q & mw_is_load & mw_wb_reg &
                      (mw_rd_num != 5'd0) &
                      ((mw_rd_num == de_rs1_num) | (mw_rd_num == de_rs2_num));

    // Next-state and stage enables; enables forced low while in reset.
    always_comb begin
        fetch_en_c  = 1'b0;
        pc_load_c   = 1'b0;
        mw_en_c     = 1'b0;
        state_d     = state_q;
        de_valid_d  = de_valid_q;
        mw_valid_d  = mw_valid_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                // MEM_WAIT behaves as RUN in the cycle mw_busy drops.
                if (mw_busy) begin
                    state_d = ST_MEM_WAIT;
                end else if (flash_hz) begin
                    mw_en_c     = 1'b1;
                    pc_load_c   = 1'b1;
                    de_valid_d  = 1'b0;
                    mw_valid_d  = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else if (redir_hz) begin
                    pc_load_c  = 1'b1;
                    fetch_en_c = 1'b1;
                    mw_en_c    = 1'b1;
                    de_valid_d = 1'b0;
                    mw_valid_d = 1'b1;
                    state_d    = ST_REDIRECT;
                end else if (lu_hz) begin
                    // Hold fetch and DE, push a bubble into MW for one cycle.
                    mw_valid_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    fetch_en_c = 1'b1;
                    mw_en_c    = de_valid_q;
                    de_valid_d = imem_valid;
                    mw_valid_d = de_valid_q;
                    state_d    = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // Frozen while memory is busy; otherwise one refill cycle.
                if (!mw_busy) begin
                    fetch_en_c = 1'b1;
                    de_valid_d = 1'b0;
                    mw_valid_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                // DRAIN: let MW retire, then idle FLUSH_CYCLES before fetching.
                de_valid_d = 1'b0;
                if (mw_busy) begin
                    flush_cnt_d = '0;
                end else if (mw_valid_q) begin
                    mw_valid_d  = 1'b0;
                    flush_cnt_d = '0;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
        endcase
        if (rst) begin
            fetch_en_c = 1'b0;
            pc_load_c  = 1'b0;
            mw_en_c    = 1'b0;
        end
    end

    // Controller state, stage valid bits and flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            de_valid_q  <= 1'b0;
            mw_valid_q  <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            de_valid_q  <= de_valid_d;
            mw_valid_q  <= mw_valid_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Saturating count of cycles in which fetch did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!fetch_en_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign fetch_en   = fetch_en_c;
    assign pc_load    = pc_load_c;
    assign mw_en      = mw_en_c;
    assign de_valid   = de_valid_q;
    assign mw_valid   = mw_valid_q;
    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, normal flow, load-use,
// redirect, memory freeze, drain, reset during drain, counter saturation.
// The stall counter is narrowed to 4 bits so saturation is reachable.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          imem_valid;
    logic [4:0]    de_rs1_num;
    logic [4:0]    de_rs2_num;
    logic          br_taken;
    logic          jump;
    logic          flash;
    logic          mw_busy;
    logic          mw_is_load;
    logic          mw_wb_reg;
    logic [4:0]    mw_rd_num;
    logic          fetch_en;
    logic          pc_load;
    logic          de_valid;
    logic          mw_en;
    logic          mw_valid;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_valid (imem_valid),
        .de_rs1_num (de_rs1_num),
        .de_rs2_num (de_rs2_num),
        .br_taken   (br_taken),
        .jump       (jump),
        .flash      (flash),
        .mw_busy    (mw_busy),
        .mw_is_load (mw_is_load),
        .mw_wb_reg  (mw_wb_reg),
        .mw_rd_num  (mw_rd_num),
        .fetch_en   (fetch_en),
        .pc_load    (pc_load),
        .de_valid   (de_valid),
        .mw_en      (mw_en),
        .mw_valid   (mw_valid),
        .ctrl_state (ctrl_state),
        .stall_cnt  (stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hz();
        de_rs1_num = 5'd0;
        de_rs2_num = 5'd0;
        br_taken   = 1'b0;
        jump       = 1'b0;
        flash      = 1'b0;
        mw_busy    = 1'b0;
        mw_is_load = 1'b0;
        mw_wb_reg  = 1'b0;
        mw_rd_num  = 5'd0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        mw_is_load = 1'b1;
        mw_wb_reg  = 1'b1;
        mw_rd_num  = rd;
        de_rs1_num = rs1;
        de_rs2_num = rs2;
    endtask

    initial begin
        rst = 1'b1;
        imem_valid = 1'b1;
        clear_hz();
        repeat (3) cyc();
        // reset state
        chk("rst_fetch_en", fetch_en, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_mw_en", mw_en, 0);
        chk("rst_de_valid", de_valid, 0);
        chk("rst_mw_valid", mw_valid, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_stall", stall_cnt, 0);

        // A: first cycle after reset
        rst = 1'b0; #1;
        chk("a_fetch_en", fetch_en, 1);
        chk("a_de_valid", de_valid, 0);
        chk("a_mw_en", mw_en, 0);
        cyc();
        // B
        chk("b_de_valid", de_valid, 1);
        chk("b_mw_valid", mw_valid, 0);
        chk("b_mw_en", mw_en, 1);
        chk("b_fetch_en", fetch_en, 1);
        cyc();
        // C: lw x5 in MW, add x6,x5,x1 in DE
        set_load(5'd5, 5'd5, 5'd1); #1;
        chk("c_mw_valid", mw_valid, 1);
        chk("c_lu_fetch_en", fetch_en, 0);
        chk("c_lu_mw_en", mw_en, 0);
        cyc();
        // D: bubble in MW
        clear_hz(); #1;
        chk("d_mw_valid", mw_valid, 0);
        chk("d_de_valid", de_valid, 1);
        chk("d_stall", stall_cnt, 1);
        chk("d_fetch_en", fetch_en, 1);
        cyc();
        // E: rd=x0 never stalls
        set_load(5'd0, 5'd0, 5'd0); #1;
        chk("e_mw_valid", mw_valid, 1);
        chk("e_rd0_fetch_en", fetch_en, 1);
        cyc();
        // F: match on rs2
        set_load(5'd1, 5'd5, 5'd1); #1;
        chk("f_rs2_fetch_en", fetch_en, 0);
        cyc();
        // G
        clear_hz(); #1;
        chk("g_mw_valid", mw_valid, 0);
        chk("g_stall", stall_cnt, 2);
        cyc();
        // H: branch taken
        br_taken = 1'b1; #1;
        chk("h_pc_load", pc_load, 1);
        chk("h_fetch_en", fetch_en, 1);
        chk("h_mw_en", mw_en, 1);
        chk("h_state", ctrl_state, 0);
        cyc();
        // I: REDIRECT
        clear_hz(); #1;
        chk("i_state", ctrl_state, 2);
        chk("i_de_valid", de_valid, 0);
        chk("i_mw_valid", mw_valid, 1);
        chk("i_fetch_en", fetch_en, 1);
        chk("i_pc_load", pc_load, 0);
        cyc();
        // J: jump ignored while de_valid=0
        jump = 1'b1; #1;
        chk("j_state", ctrl_state, 0);
        chk("j_de_valid", de_valid, 0);
        chk("j_mw_valid", mw_valid, 0);
        chk("j_pc_load", pc_load, 0);
        chk("j_fetch_en", fetch_en, 1);
        cyc();
        // K
        clear_hz(); #1;
        chk("k_de_valid", de_valid, 1);
        chk("k_mw_valid", mw_valid, 0);
        cyc();
        // L: memory busy 4 cycles
        mw_busy = 1'b1; #1;
        chk("l_state", ctrl_state, 0);
        chk("l_fetch_en", fetch_en, 0);
        chk("l_mw_valid", mw_valid, 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("m_state", ctrl_state, 1);
            chk("m_fetch_en", fetch_en, 0);
            chk("m_de_valid", de_valid, 1);
            chk("m_mw_valid", mw_valid, 1);
            cyc();
        end
        mw_busy = 1'b0; #1;
        chk("m4_state", ctrl_state, 1);
        chk("m4_fetch_en", fetch_en, 1);
        chk("m4_mw_en", mw_en, 1);
        cyc();
        // N: back to RUN, then flash
        chk("n_state", ctrl_state, 0);
        chk("n_stall", stall_cnt, 6);
        flash = 1'b1; #1;
        chk("n_fetch_en", fetch_en, 0);
        chk("n_pc_load", pc_load, 1);
        chk("n_mw_en", mw_en, 1);
        cyc();
        // D1: DRAIN with MW busy
        flash = 1'b0; mw_busy = 1'b1; #1;
        chk("d1_state", ctrl_state, 3);
        chk("d1_de_valid", de_valid, 0);
        chk("d1_mw_valid", mw_valid, 1);
        chk("d1_fetch_en", fetch_en, 0);
        cyc();
        mw_busy = 1'b0; #1;
        chk("d1b_mw_valid", mw_valid, 1);
        chk("d1b_state", ctrl_state, 3);
        cyc();
        chk("d2_mw_valid", mw_valid, 0);
        chk("d2_state", ctrl_state, 3);
        chk("d2_fetch_en", fetch_en, 0);
        cyc();
        chk("d3_state", ctrl_state, 3);
        chk("d3_fetch_en", fetch_en, 0);
        cyc();
        chk("d4_state", ctrl_state, 0);
        chk("d4_fetch_en", fetch_en, 1);
        chk("d4_stall", stall_cnt, 11);
        cyc();
        // D5: refill DE, then flash again
        chk("d5_de_valid", de_valid, 1);
        flash = 1'b1; #1;
        chk("d5_fetch_en", fetch_en, 0);
        cyc();
        flash = 1'b0; #1;
        chk("e1_state", ctrl_state, 3);
        chk("e1_mw_valid", mw_valid, 1);
        cyc();
        chk("e2_mw_valid", mw_valid, 0);
        cyc();
        // E3: mid-count in DRAIN, assert reset
        chk("e3_state", ctrl_state, 3);
        rst = 1'b1; #1;
        chk("e3_rst_fetch_en", fetch_en, 0);
        cyc();
        chk("e4_state", ctrl_state, 0);
        chk("e4_de_valid", de_valid, 0);
        chk("e4_mw_valid", mw_valid, 0);
        chk("e4_stall", stall_cnt, 0);
        chk("e4_pc_load", pc_load, 0);
        chk("e4_mw_en", mw_en, 0);
        rst = 1'b0; #1;
        chk("e4_fetch_en", fetch_en, 1);
        cyc();
        // saturation of the stall counter
        mw_busy = 1'b1;
        repeat (20) cyc();
        chk("sat_stall", stall_cnt, 15);
        chk("sat_state", ctrl_state, 1);
        mw_busy = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
